// File: rtl/booth_psum_accum_pkg.sv
// Shared constants and types for the Booth partial-sum accumulator.
package booth_pkg;

    localparam int PS_W   = 13;
    localparam int PROD_W = 16;
    localparam int NUM_PS = 4;

    typedef logic signed [PS_W-1:0]   psum_t;
    typedef logic signed [PROD_W-1:0] prod_t;

    // Sign-extend a partial sum to the product width before any shifting.
    function automatic prod_t sext_ps(input psum_t p);
        return {{(PROD_W-PS_W){p[PS_W-1]}}, p};
    endfunction

endpackage

// File: rtl/booth_psum_accum_if.sv
// Handshake bus between the Booth decoder, the accumulator and its consumer.
interface booth_psum_accum_if;
    import booth_pkg::*;

    logic  in_valid;
    logic  in_ready;
    psum_t ps0;
    psum_t ps1;
    psum_t ps2;
    psum_t ps3;
    logic  out_valid;
    logic  out_ready;
    prod_t product;

    // Environment side: produces partial sums and consumes products.
    modport master (
        output in_valid, ps0, ps1, ps2, ps3, out_ready,
        input  in_ready, out_valid, product
    );

    // Accumulator side.
    modport slave (
        input  in_valid, ps0, ps1, ps2, ps3, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/booth_psum_accum_pipe_slot.sv
// Generic single-entry valid/ready register slot. Accepts whenever it is empty
// or its content leaves in the same cycle, giving full throughput.
module booth_pipe_slot #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);
    logic         valid_reg;
    logic [W-1:0] data_reg;
    logic         load;

    assign load      = !valid_reg || out_ready;
    assign in_ready  = load;
    assign out_valid = valid_reg;
    assign out_data  = data_reg;

    // Occupancy: refreshed whenever the slot is free to load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            valid_reg <= 1'b0;
        else if (load)
            valid_reg <= in_valid;
    end

    // Data is captured only on a real transfer so a stalled slot keeps its value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            data_reg <= '0;
        else if (load && in_valid)
            data_reg <= in_data;
    end
endmodule

// File: rtl/booth_psum_accum.sv
// Reduces four radix-4 Booth partial sums to a 16-bit product through a
// two-slot valid/ready pipeline (pair sums in slot A, final sum in slot B).
// Optional feature macro: BOOTH_PSUM_CNT_EN adds prod_cnt, a wrapping count of
// products accepted by the consumer.
module booth_psum_accum
    import booth_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    booth_psum_accum_if.slave bus
`ifdef BOOTH_PSUM_CNT_EN
    ,
    output logic [15:0]       prod_cnt
`endif
);
    psum_t ps_arr [NUM_PS];
    prod_t term   [NUM_PS];

    assign ps_arr[0] = bus.ps0;
    assign ps_arr[1] = bus.ps1;
    assign ps_arr[2] = bus.ps2;
    assign ps_arr[3] = bus.ps3;

    // Each partial sum is weighted by 4^i after sign extension; overflow wraps.
    generate
        for (genvar gi = 0; gi < NUM_PS; gi++) begin : g_term
            assign term[gi] = sext_ps(ps_arr[gi]) <<< (2 * gi);
        end
    endgenerate

    prod_t                lo;
    prod_t                hi;
    logic [2*PROD_W-1:0]  a_in_data;
    logic [2*PROD_W-1:0]  a_data;
    logic                 a_valid;
    logic                 b_in_ready;
    prod_t                b_in_data;
    logic                 b_valid;

    assign lo        = term[0] + term[1];
    assign hi        = term[2] + term[3];
    assign a_in_data = {hi, lo};
    assign b_in_data = prod_t'(a_data[2*PROD_W-1:PROD_W]) + prod_t'(a_data[PROD_W-1:0]);

    booth_pipe_slot #(.W(2 * PROD_W)) u_slot_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_data   (a_in_data),
        .in_ready  (bus.in_ready),
        .out_valid (a_valid),
        .out_data  (a_data),
        .out_ready (b_in_ready)
    );

    booth_pipe_slot #(.W(PROD_W)) u_slot_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_valid),
        .in_data   (b_in_data),
        .in_ready  (b_in_ready),
        .out_valid (b_valid),
        .out_data  (bus.product),
        .out_ready (bus.out_ready)
    );

    assign bus.out_valid = b_valid;

`ifdef BOOTH_PSUM_CNT_EN
    logic [15:0] cnt_reg;

    // Count every product the consumer takes; natural 16-bit wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_reg <= 16'h0000;
        else if (b_valid && bus.out_ready)
            cnt_reg <= cnt_reg + 16'h0001;
    end

    assign prod_cnt = cnt_reg;
`endif
endmodule

// File: tb/tb_booth_psum_accum.sv
// Self-checking bench for booth_psum_accum: directed vectors, streaming,
// stall, asynchronous reset and randomized traffic against an arithmetic model.
module tb_booth_psum_accum;
    import booth_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    booth_psum_accum_if bif ();

`ifdef BOOTH_PSUM_CNT_EN
    logic [15:0] prod_cnt;
    booth_psum_accum dut (.clk(clk), .rst_n(rst_n), .bus(bif), .prod_cnt(prod_cnt));
`else
    booth_psum_accum dut (.clk(clk), .rst_n(rst_n), .bus(bif));
`endif

    int          total = 0;
    int          bad   = 0;
    int          cnt_model = 0;
    logic [15:0] exp_q [$];

    // Product from the weighted-sum definition using plain integer arithmetic.
    function automatic logic [15:0] ref_prod(input psum_t a, input psum_t b,
                                             input psum_t c, input psum_t d);
        int s;
        s = int'(a) + 4 * int'(b) + 16 * int'(c) + 64 * int'(d);
        return s[15:0];
    endfunction

    task automatic rand_ps();
        bif.ps0 = psum_t'($urandom);
        bif.ps1 = psum_t'($urandom);
        bif.ps2 = psum_t'($urandom);
        bif.ps3 = psum_t'($urandom);
    endtask

    // One clock: sample handshakes before the edge, record accepted inputs.
    task automatic tick(output bit ai, output bit ao, output bit ov, output logic [15:0] pv);
        #1;
        ai = bif.in_valid && bif.in_ready;
        ov = bif.out_valid;
        ao = bif.out_valid && bif.out_ready;
        pv = bif.product;
        if (ai) exp_q.push_back(ref_prod(bif.ps0, bif.ps1, bif.ps2, bif.ps3));
        if (ao) cnt_model++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bif.in_valid = 1'b0; bif.out_ready = 1'b0;
        bif.ps0 = '0; bif.ps1 = '0; bif.ps2 = '0; bif.ps3 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (bif.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bif.out_valid); end
        total++;
        if (bif.product !== 16'h0000) begin bad++; $display("FAIL reset_product: got %h want 0000", bif.product); end
        rst_n = 1'b1;
        #1;
        total++;
        if (bif.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bif.in_ready); end
        exp_q.delete();
        cnt_model = 0;
`ifdef BOOTH_PSUM_CNT_EN
        total++;
        if (prod_cnt !== 16'h0000) begin bad++; $display("FAIL reset_prod_cnt: got %h want 0000", prod_cnt); end
`endif
    endtask

    task automatic test_latency();
        bit ai, ao, ov; logic [15:0] pv;
        bif.ps0 = 13'h0003; bif.ps1 = 13'h0001; bif.ps2 = 13'h0000; bif.ps3 = 13'h0000;
        bif.in_valid = 1'b1; bif.out_ready = 1'b1;
        tick(ai, ao, ov, pv);
        total++;
        if (ai !== 1'b1) begin bad++; $display("FAIL lat_accept: got %b want 1", ai); end
        bif.in_valid = 1'b0;
        tick(ai, ao, ov, pv);
        total++;
        if (ov !== 1'b0) begin bad++; $display("FAIL lat_early_valid: got %b want 0", ov); end
        tick(ai, ao, ov, pv);
        total++;
        if (ov !== 1'b1 || pv !== 16'h0007) begin
            bad++; $display("FAIL lat_product: got valid=%b prod=%h want valid=1 prod=0007", ov, pv);
        end
        if (ao) void'(exp_q.pop_front());
    endtask

    task automatic test_directed();
        bit ai, ao, ov; logic [15:0] pv;
        psum_t       v0 [3];
        psum_t       v3 [3];
        logic [15:0] want [3];
        bit          got;
        v0[0] = 13'h1FFF; v3[0] = 13'h0000; want[0] = 16'hFFFF;
        v0[1] = 13'h0000; v3[1] = 13'h0001; want[1] = 16'h0040;
        v0[2] = 13'h0000; v3[2] = 13'h0FFF; want[2] = 16'hFFC0;
        bif.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bif.ps0 = v0[k]; bif.ps1 = '0; bif.ps2 = '0; bif.ps3 = v3[k];
            bif.in_valid = 1'b1;
            tick(ai, ao, ov, pv);
            bif.in_valid = 1'b0;
            got = 1'b0;
            for (int c = 0; c < 6 && !got; c++) begin
                tick(ai, ao, ov, pv);
                if (ao) begin
                    got = 1'b1;
                    void'(exp_q.pop_front());
                    total++;
                    if (pv !== want[k]) begin bad++; $display("FAIL directed_%0d: got %h want %h", k, pv, want[k]); end
                end
            end
            if (!got) begin total++; bad++; $display("FAIL directed_%0d_timeout: got none want %h", k, want[k]); end
        end
    endtask

    task automatic test_back_to_back();
        bit ai, ao, ov; logic [15:0] pv, e;
        int n_out = 0, first = -1, last = -1;
        bif.out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i < 8) begin rand_ps(); bif.in_valid = 1'b1; end
            else bif.in_valid = 1'b0;
            tick(ai, ao, ov, pv);
            if (i < 8) begin
                total++;
                if (ai !== 1'b1) begin bad++; $display("FAIL b2b_in_ready_%0d: got %b want 1", i, ai); end
            end
            if (ao) begin
                e = exp_q.pop_front();
                total++;
                if (pv !== e) begin bad++; $display("FAIL b2b_product_%0d: got %h want %h", n_out, pv, e); end
                if (first < 0) first = i;
                last = i;
                n_out++;
            end
        end
        total++;
        if (n_out != 8 || last - first != 7) begin
            bad++; $display("FAIL b2b_timing: got count=%0d span=%0d want count=8 span=7", n_out, last - first);
        end
    endtask

    task automatic test_stall();
        bit ai, ao, ov; logic [15:0] pv, e, held;
        int n_out = 0;
        bif.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_ps(); bif.in_valid = 1'b1;
            tick(ai, ao, ov, pv);
            total++;
            if (ai !== (i < 2)) begin bad++; $display("FAIL stall_accept_%0d: got %b want %b", i, ai, (i < 2)); end
        end
        held = exp_q[0];
        for (int i = 0; i < 4; i++) begin
            tick(ai, ao, ov, pv);
            total++;
            if (ov !== 1'b1 || pv !== held || ai !== 1'b0) begin
                bad++; $display("FAIL stall_hold_%0d: got valid=%b prod=%h acc=%b want valid=1 prod=%h acc=0", i, ov, pv, ai, held);
            end
        end
        bif.out_ready = 1'b1;
        for (int c = 0; c < 10 && n_out < 3; c++) begin
            tick(ai, ao, ov, pv);
            if (ai) bif.in_valid = 1'b0;
            if (ao) begin
                e = exp_q.pop_front();
                total++;
                if (pv !== e) begin bad++; $display("FAIL stall_drain_%0d: got %h want %h", n_out, pv, e); end
                n_out++;
            end
        end
        total++;
        if (n_out != 3) begin bad++; $display("FAIL stall_drain_count: got %0d want 3", n_out); end
        bif.in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        bit ai, ao, ov; logic [15:0] pv, e;
        bit got = 1'b0;
        bif.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin rand_ps(); bif.in_valid = 1'b1; tick(ai, ao, ov, pv); end
        bif.in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (bif.out_valid !== 1'b0 || bif.product !== 16'h0000) begin
            bad++; $display("FAIL async_reset: got valid=%b prod=%h want valid=0 prod=0000", bif.out_valid, bif.product);
        end
        exp_q.delete();
        cnt_model = 0;
        @(negedge clk);
        rst_n = 1'b1;
        rand_ps(); bif.in_valid = 1'b1; bif.out_ready = 1'b1;
        tick(ai, ao, ov, pv);
        bif.in_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick(ai, ao, ov, pv);
            if (ao) begin
                total++;
                if (got || exp_q.size() == 0) begin
                    bad++; $display("FAIL post_reset_stale: got extra product %h want none", pv);
                end else begin
                    e = exp_q.pop_front();
                    if (pv !== e) begin bad++; $display("FAIL post_reset_product: got %h want %h", pv, e); end
                end
                got = 1'b1;
            end
        end
        if (!got) begin total++; bad++; $display("FAIL post_reset_timeout: got none want 1 product"); end
    endtask

    task automatic test_random();
        bit ai, ao, ov; logic [15:0] pv, e;
        bit          prev_hold = 1'b0;
        logic [15:0] prev_prod = '0;
        bif.in_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!bif.in_valid) begin
                bif.in_valid = ($urandom_range(0, 9) < 7);
                rand_ps();
            end
            bif.out_ready = ($urandom_range(0, 9) < 6);
            tick(ai, ao, ov, pv);
            if (prev_hold) begin
                total++;
                if (ov !== 1'b1 || pv !== prev_prod) begin
                    bad++; $display("FAIL rand_hold_%0d: got valid=%b prod=%h want valid=1 prod=%h", i, ov, pv, prev_prod);
                end
            end
            prev_hold = ov && !ao;
            prev_prod = pv;
            if (ao) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL rand_extra_%0d: got %h want none", i, pv); end
                else begin
                    e = exp_q.pop_front();
                    if (pv !== e) begin bad++; $display("FAIL rand_product_%0d: got %h want %h", i, pv, e); end
                end
            end
            if (ai) bif.in_valid = 1'b0;
        end
        bif.in_valid = 1'b0; bif.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick(ai, ao, ov, pv);
            if (ao && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                if (pv !== e) begin bad++; $display("FAIL rand_drain: got %h want %h", pv, e); end
            end
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL rand_leftover: got %0d pending want 0", exp_q.size()); end
    endtask

`ifdef BOOTH_PSUM_CNT_EN
    task automatic test_counter();
        bit ai, ao, ov; logic [15:0] pv;
        int pushed = 0;
        bif.out_ready = 1'b0;
        // Three inputs under stall, then release with a refill, then two more.
        for (int c = 0; c < 40 && cnt_model < 5; c++) begin
            if (!bif.in_valid && pushed < 5) begin rand_ps(); bif.in_valid = 1'b1; end
            if (c == 6) bif.out_ready = 1'b1;
            tick(ai, ao, ov, pv);
            if (ai) begin bif.in_valid = 1'b0; pushed++; end
            if (ao) void'(exp_q.pop_front());
        end
        total++;
        if (prod_cnt !== 16'd5 || cnt_model != 5) begin
            bad++; $display("FAIL cnt_five: got %0d want 5 (model %0d)", prod_cnt, cnt_model);
        end
        test_reset();
        bif.in_valid = 1'b1; bif.out_ready = 1'b1;
        for (int c = 0; c < 65600 && cnt_model < 65536; c++) begin
            if (cnt_model >= 65534) bif.in_valid = 1'b0;
            rand_ps();
            tick(ai, ao, ov, pv);
            if (ao) void'(exp_q.pop_front());
        end
        total++;
        if (prod_cnt !== 16'h0000 || cnt_model != 65536) begin
            bad++; $display("FAIL cnt_wrap: got %h want 0000 (model %0d)", prod_cnt, cnt_model);
        end
        bif.in_valid = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_back_to_back();
        test_stall();
        test_async_reset();
        test_random();
`ifdef BOOTH_PSUM_CNT_EN
        test_reset();
        test_counter();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
